// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : seg_scan_ctrl
//  Description : Digit-scan controller for a multiplexed hex 7-segment
//                display. Divides clk into per-digit slots, cycles the digit
//                index, and applies new display values only at frame
//                boundaries through a one-entry pending buffer fed by a
//                valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_ctrl #(
   parameter int CLK_DIV    = 50000,  // clocks per digit slot (>= 2)
   parameter int NUM_DIGITS = 6,      // digits per frame (2..8)
   parameter int DIV_W      = 16      // divider width, 2**DIV_W >= CLK_DIV
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic [23:0] din,
   input  logic        din_valid,
   output logic        din_ready,
   output logic [23:0] disp_num,
   output logic [2:0]  Scanning,
   output logic        frame_start,
   output logic        blank
);

   // Terminal values for the slot divider and the digit index.
   localparam logic [DIV_W-1:0] C_DIV_LAST   = DIV_W'(CLK_DIV - 1);
   localparam logic [2:0]       C_DIGIT_LAST = 3'(NUM_DIGITS - 1);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t            state_q,       state_d;
   logic [DIV_W-1:0]  div_q,         div_d;
   logic [2:0]        scan_q,        scan_d;
   logic [23:0]       disp_q,        disp_d;
   logic [23:0]       pend_q,        pend_d;
   logic              pend_full_q,   pend_full_d;
   logic              frame_start_q, frame_start_d;
   logic              blank_q,       blank_d;

   logic              w_tick;        // last clock of the current digit slot
   logic              w_frame_wrap;  // last clock of the last digit slot
   logic              w_apply_now;   // this edge starts a new frame
   logic              w_accept;      // handshake transfer on this edge

   // Frame-boundary detection and handshake qualification.
   always_comb begin
      w_tick       = (state_q == ST_RUN) && (div_q == C_DIV_LAST);
      w_frame_wrap = w_tick && (scan_q == C_DIGIT_LAST);
      // A disable always wins, so neither entry nor wrap counts without en.
      w_apply_now  = en && ((state_q == ST_IDLE) || w_frame_wrap);
      // The pending slot frees up on an apply edge, so a new word may enter
      // on the very same edge the old one moves to the display.
      din_ready    = !pend_full_q || w_apply_now;
      w_accept     = din_valid && din_ready;
   end

   // Next-state logic for the scan FSM, divider and digit index.
   always_comb begin
      state_d       = state_q;
      div_d         = '0;
      scan_d        = '0;
      frame_start_d = 1'b0;
      blank_d       = 1'b1;

      case (state_q)
         ST_IDLE: begin
            if (en) begin
               state_d       = ST_RUN;
               frame_start_d = 1'b1;
               blank_d       = 1'b0;
            end
         end
         ST_RUN: begin
            if (!en) begin
               // Drop out mid-frame: return to digit 0 and go dark quietly.
               state_d = ST_IDLE;
            end else begin
               blank_d = 1'b0;
               if (w_tick) begin
                  div_d = '0;
                  if (w_frame_wrap) begin
                     scan_d        = '0;
                     frame_start_d = 1'b1;
                  end else begin
                     scan_d = scan_q + 3'd1;
                  end
               end else begin
                  div_d  = div_q + DIV_W'(1);
                  scan_d = scan_q;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Pending buffer and display register: apply first, then accept, so a
   // simultaneous accept displays the old pending word and keeps the new one.
   always_comb begin
      disp_d      = disp_q;
      pend_d      = pend_q;
      pend_full_d = pend_full_q;

      if (w_apply_now && pend_full_q) begin
         disp_d      = pend_q;
         pend_full_d = 1'b0;
      end

      if (w_accept) begin
         pend_d      = din;
         pend_full_d = 1'b1;
      end
   end

   // State register; reset discards any pending word immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         div_q         <= '0;
         scan_q        <= '0;
         disp_q        <= '0;
         pend_q        <= '0;
         pend_full_q   <= 1'b0;
         frame_start_q <= 1'b0;
         blank_q       <= 1'b1;
      end else begin
         state_q       <= state_d;
         div_q         <= div_d;
         scan_q        <= scan_d;
         disp_q        <= disp_d;
         pend_q        <= pend_d;
         pend_full_q   <= pend_full_d;
         frame_start_q <= frame_start_d;
         blank_q       <= blank_d;
      end
   end

   assign disp_num    = disp_q;
   assign Scanning    = scan_q;
   assign frame_start = frame_start_q;
   assign blank       = blank_q;

endmodule
`default_nettype wire
